estagio_id_ex: RTL
==================

# estagio_id_ex

Pipeline stage register between decode and the ALU. It latches decoded operands and control, and applies operand forwarding from the MEM and WB stages. It detects load-use hazards and inserts bubbles on stall or flush. Its outputs `w_rd1SrcA`, `w_SrcB` and `ULAControl` drive the ALU directly.

## Interface
Parameters:
- XLEN, 32, datapath width
- REGW, 5, register index width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode stage holds a valid instruction
- id_rs1, id_rs2, id_rd  in  REGW  source and destination register indices
- id_rd1, id_rd2  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate
- id_ULASrc  in  1  1 = SrcB takes the immediate, 0 = SrcB takes rs2
- id_ULAControl  in  3  ALU opcode, passed through
- id_RegWrite, id_MemRead, id_MemWrite  in  1  control bits
- flush  in  1  branch/jump redirect; kill the instruction entering EX
- mem_rd  in  REGW, mem_RegWrite  in  1, mem_result  in  XLEN  EX/MEM forwarding source
- wb_rd  in  REGW, wb_RegWrite  in  1, wb_result  in  XLEN  WB forwarding and write-back source
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  EX holds a real instruction
- w_rd1SrcA  out  XLEN  ALU operand A, after forwarding
- w_SrcB  out  XLEN  ALU operand B, after forwarding and the immediate mux
- ULAControl  out  3  ALU opcode
- ex_rd2_fwd  out  XLEN  forwarded rs2 value, used as store data
- ex_rd  out  REGW; ex_RegWrite, ex_MemRead, ex_MemWrite  out  1  control passed down

## Operation
- **Registered fields:** valid, rs1, rs2, rd, rd1, rd2, imm, ULASrc, ULAControl, RegWrite, MemRead, MemWrite.
- **Load at each edge:**
  - A bubble is loaded if reset, flush, stall, or !id_valid.
  - Otherwise the id_* inputs are loaded.
- **Bubble:** every registered field is 0. The outputs are then all 0 (rs=0 never forwards) and ex_valid=0.
- **Decode-stage bypass at capture:** if wb_RegWrite && wb_rd!=0 && wb_rd==id_rs1, latch wb_result instead of id_rd1. The same rule applies to rs2/id_rd2.
- **EX forwarding (combinational, on registered rs1 and rs2 independently):**
  - MEM match: mem_RegWrite && mem_rd!=0 && mem_rd==rs selects mem_result.
  - Otherwise WB match (same form) selects wb_result.
  - Otherwise the registered rd1/rd2 is used.
  - MEM has priority over WB.
- **Operand outputs:**
  - w_rd1SrcA = forwarded A.
  - ex_rd2_fwd = forwarded B.
  - w_SrcB = ULASrc ? imm : forwarded B.
- **Load-use hazard:** stall = ex_valid && ex_MemRead && ex_rd!=0 && id_valid && (id_rs1==ex_rd || id_rs2==ex_rd) && !flush.
- **Flush vs. stall:** flush overrides stall. When flush is asserted, stall=0 and a bubble is loaded.
- **Arithmetic:** none; the block only routes and muxes. All data paths are XLEN wide with no truncation.

## Timing
- **Reset:** synchronous. After the first edge with reset=1, all registered fields and outputs are 0, stall=0, ex_valid=0. Asserting reset mid-stream discards the EX instruction at that edge.
- **Latency:** one cycle from ID inputs to EX outputs.
- **Forwarding:** combinational, zero extra cycles.
- **Stall:** asserted in the same cycle as the hazard. Exactly one bubble is inserted. In the following cycle the load has moved to MEM, the dependent instruction (still presented on id_* by the held IF/ID) is captured, and the loaded value is forwarded from WB one cycle later.
- **Back-to-back loads:** each dependent consumer gets exactly one stall cycle.
- **Independent instruction behind a load:** stall=0 and it issues with no bubble.

## Test plan
1. **Reset mid-stream:** with a valid ADD in EX (ex_valid=1, ULAControl=000), assert reset for 2 cycles → at the first reset edge and after, all outputs are 0, ex_valid=0 and stall=0.
2. **MEM forwarding priority:**
   - Stimulus: EX holds rs1=5 with latched rd1=0x0000AAAA; mem_rd=5, mem_RegWrite=1, mem_result=0x00001234; wb_rd=5, wb_RegWrite=1, wb_result=0x00005678.
   - Response: w_rd1SrcA=0x00001234.
   - Then drop mem_RegWrite → w_rd1SrcA=0x00005678.
3. **x0 never forwarded:** EX holds rs1=0, rd1=0; mem_rd=0, mem_RegWrite=1, mem_result=0xFFFFFFFF → w_rd1SrcA=0.
4. **Load-use hazard:**
   - Stimulus: EX holds LW (MemRead=1) with rd=7; ID holds id_rs2=7, id_valid=1.
   - Response: stall=1 that cycle; at the next edge ex_valid=0 and ULAControl=000; the next cycle stall=0 and the consumer latches.
   - With wb_rd=7, wb_result=0xCAFEBABE, the consumer sees ex_rd2_fwd=0xCAFEBABE.
5. **Flush during stall:** hazard as in scenario 4, plus flush=1 → stall=0 and a bubble is loaded (ex_valid=0, ex_RegWrite=0).
6. **Immediate select and decode bypass:**
   - Stimulus: id_ULASrc=1, id_imm=0xFFFFFFF0, id_rs2=3, id_rd2=0x11; the same cycle wb_rd=3, wb_RegWrite=1, wb_result=0x22.
   - Response: in EX, w_SrcB=0xFFFFFFF0 and ex_rd2_fwd=0x22.

Source files
------------

// File: rtl/estagio_id_ex_if.sv
// ---------------------------------------------------------------------------
// estagio_id_ex_if
// Signal bundle between the decode stage, the forwarding sources and the
// ID/EX pipeline register.
//
//   Decode side  : id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
//                  id_ULASrc, id_ULAControl, id_RegWrite, id_MemRead,
//                  id_MemWrite, flush
//   Forwarding   : mem_rd, mem_RegWrite, mem_result,
//                  wb_rd, wb_RegWrite, wb_result
//   EX side      : stall, ex_valid, w_rd1SrcA, w_SrcB, ULAControl,
//                  ex_rd2_fwd, ex_rd, ex_RegWrite, ex_MemRead, ex_MemWrite
//
// master : the surrounding pipeline (drives decode and forwarding signals)
// slave  : the ID/EX register itself
// ---------------------------------------------------------------------------
interface estagio_id_ex_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);

  // Decode stage
  logic            id_valid;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic [REGW-1:0] id_rd;
  logic [XLEN-1:0] id_rd1;
  logic [XLEN-1:0] id_rd2;
  logic [XLEN-1:0] id_imm;
  logic            id_ULASrc;
  logic [2:0]      id_ULAControl;
  logic            id_RegWrite;
  logic            id_MemRead;
  logic            id_MemWrite;
  logic            flush;

  // Forwarding sources
  logic [REGW-1:0] mem_rd;
  logic            mem_RegWrite;
  logic [XLEN-1:0] mem_result;
  logic [REGW-1:0] wb_rd;
  logic            wb_RegWrite;
  logic [XLEN-1:0] wb_result;

  // Execute stage
  logic            stall;
  logic            ex_valid;
  logic [XLEN-1:0] w_rd1SrcA;
  logic [XLEN-1:0] w_SrcB;
  logic [2:0]      ULAControl;
  logic [XLEN-1:0] ex_rd2_fwd;
  logic [REGW-1:0] ex_rd;
  logic            ex_RegWrite;
  logic            ex_MemRead;
  logic            ex_MemWrite;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
           id_ULASrc, id_ULAControl, id_RegWrite, id_MemRead, id_MemWrite,
           flush,
           mem_rd, mem_RegWrite, mem_result,
           wb_rd, wb_RegWrite, wb_result,
    input  stall, ex_valid, w_rd1SrcA, w_SrcB, ULAControl, ex_rd2_fwd,
           ex_rd, ex_RegWrite, ex_MemRead, ex_MemWrite
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
           id_ULASrc, id_ULAControl, id_RegWrite, id_MemRead, id_MemWrite,
           flush,
           mem_rd, mem_RegWrite, mem_result,
           wb_rd, wb_RegWrite, wb_result,
    output stall, ex_valid, w_rd1SrcA, w_SrcB, ULAControl, ex_rd2_fwd,
           ex_rd, ex_RegWrite, ex_MemRead, ex_MemWrite
  );

endinterface

// File: rtl/estagio_id_ex.sv
// ---------------------------------------------------------------------------
// estagio_id_ex
// ID/EX pipeline register. Latches the decoded operands and control bits,
// bypasses the WB result into the operands while capturing, forwards MEM/WB
// results onto the ALU operands in EX, and detects load-use hazards.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; loads a bubble
//   bus    : estagio_id_ex_if.slave (decode inputs, forwarding sources,
//            EX outputs and the combinational stall request)
// ---------------------------------------------------------------------------
module estagio_id_ex #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic           clk,
  input  logic           reset,
  estagio_id_ex_if.slave bus
);

  // Registered EX fields
  logic            ex_valid_q;
  logic [REGW-1:0] ex_rs1_q;
  logic [REGW-1:0] ex_rs2_q;
  logic [REGW-1:0] ex_rd_q;
  logic [XLEN-1:0] ex_rd1_q;
  logic [XLEN-1:0] ex_rd2_q;
  logic [XLEN-1:0] ex_imm_q;
  logic            ex_ulasrc_q;
  logic [2:0]      ex_ulactl_q;
  logic            ex_regwrite_q;
  logic            ex_memread_q;
  logic            ex_memwrite_q;

  logic            stall_c;
  logic            load_bubble;
  logic [XLEN-1:0] rd1_capture;
  logic [XLEN-1:0] rd2_capture;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // A source register matches a producer only when the producer really
  // writes and the index is not x0.
  function automatic logic producer_hit(input logic            wr_en,
                                        input logic [REGW-1:0] prod_rd,
                                        input logic [REGW-1:0] rs);
    return wr_en && (prod_rd != '0) && (prod_rd == rs);
  endfunction

  // EX forwarding: MEM is the younger producer, so it wins over WB.
  function automatic logic [XLEN-1:0] forward_operand(input logic [REGW-1:0] rs,
                                                      input logic [XLEN-1:0] latched);
    if (producer_hit(bus.mem_RegWrite, bus.mem_rd, rs))
      return bus.mem_result;
    else if (producer_hit(bus.wb_RegWrite, bus.wb_rd, rs))
      return bus.wb_result;
    else
      return latched;
  endfunction

  // Load-use hazard: the load in EX has not produced its data yet, so the
  // dependent instruction in ID must wait one cycle. A flush kills the
  // dependent instruction anyway, so it never stalls.
  always_comb begin
    stall_c = ex_valid_q && ex_memread_q && (ex_rd_q != '0) && bus.id_valid &&
              ((bus.id_rs1 == ex_rd_q) || (bus.id_rs2 == ex_rd_q)) &&
              !bus.flush;
  end

  // The register file is written at the end of WB, so a read in ID during
  // the same cycle sees the stale value; take the WB result instead.
  always_comb begin
    rd1_capture = producer_hit(bus.wb_RegWrite, bus.wb_rd, bus.id_rs1) ?
                  bus.wb_result : bus.id_rd1;
    rd2_capture = producer_hit(bus.wb_RegWrite, bus.wb_rd, bus.id_rs2) ?
                  bus.wb_result : bus.id_rd2;
  end

  assign load_bubble = reset || bus.flush || stall_c || !bus.id_valid;

  // Bubble clears every field, which also makes rs1/rs2 zero so a bubble
  // can never pick up a forwarded value.
  always_ff @(posedge clk) begin
    if (load_bubble) begin
      ex_valid_q    <= 1'b0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_rd1_q      <= '0;
      ex_rd2_q      <= '0;
      ex_imm_q      <= '0;
      ex_ulasrc_q   <= 1'b0;
      ex_ulactl_q   <= 3'b000;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
    end else begin
      ex_valid_q    <= 1'b1;
      ex_rs1_q      <= bus.id_rs1;
      ex_rs2_q      <= bus.id_rs2;
      ex_rd_q       <= bus.id_rd;
      ex_rd1_q      <= rd1_capture;
      ex_rd2_q      <= rd2_capture;
      ex_imm_q      <= bus.id_imm;
      ex_ulasrc_q   <= bus.id_ULASrc;
      ex_ulactl_q   <= bus.id_ULAControl;
      ex_regwrite_q <= bus.id_RegWrite;
      ex_memread_q  <= bus.id_MemRead;
      ex_memwrite_q <= bus.id_MemWrite;
    end
  end

  always_comb begin
    fwd_a = forward_operand(ex_rs1_q, ex_rd1_q);
    fwd_b = forward_operand(ex_rs2_q, ex_rd2_q);
  end

  assign bus.stall       = stall_c;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.w_rd1SrcA   = fwd_a;
  assign bus.ex_rd2_fwd  = fwd_b;
  assign bus.w_SrcB      = ex_ulasrc_q ? ex_imm_q : fwd_b;
  assign bus.ULAControl  = ex_ulactl_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_RegWrite = ex_regwrite_q;
  assign bus.ex_MemRead  = ex_memread_q;
  assign bus.ex_MemWrite = ex_memwrite_q;

endmodule
